// File: rtl/regfile_dump_ctrl.sv
// Read-side sweeper for the register file: walks R0..R(NUM_REGS-1) through one
// combinational read port, streams each captured value with its index over a
// valid/ready interface, and flags a stale snapshot when an already captured
// register is written while the sweep is in progress.
module regfile_dump_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [SEL_W-1:0]  rf_sel,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic              stale
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);
  localparam logic [SEL_W-1:0] ONE_IDX  = SEL_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } stateT;

  stateT             stateQ, stateD;
  logic [SEL_W-1:0]  idxQ, idxD;
  logic              validQ, validD;
  logic [DATA_W-1:0] dataQ, dataD;
  logic [SEL_W-1:0]  outIdxQ, outIdxD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic              staleQ, staleD;
  logic              staleHit;

  // State and output registers; reset aborts any sweep in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= IDLE;
      idxQ    <= '0;
      validQ  <= 1'b0;
      dataQ   <= '0;
      outIdxQ <= '0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      staleQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      idxQ    <= idxD;
      validQ  <= validD;
      dataQ   <= dataD;
      outIdxQ <= outIdxD;
      busyQ   <= busyD;
      doneQ   <= doneD;
      staleQ  <= staleD;
    end
  end

  // Next-state, capture, handshake and stale tracking.
  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    validD   = validQ;
    dataD    = dataQ;
    outIdxD  = outIdxQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    staleD   = staleQ;
    staleHit = 1'b0;

    // A write hits the snapshot if its register was already read: anything
    // below idx, or idx itself once the READ cycle has sampled it (no bypass,
    // so a same-cycle write is missed by the capture).
    if ((stateQ != IDLE) && wr_en) begin
      if (wr_sel < idxQ) begin
        staleHit = 1'b1;
      end else if ((wr_sel == idxQ) && ((stateQ == READ) || (stateQ == SEND))) begin
        staleHit = 1'b1;
      end
    end
    if (staleHit) begin
      staleD = 1'b1;
    end

    case (stateQ)
      IDLE: begin
        if (start) begin
          staleD = 1'b0;
          idxD   = '0;
          busyD  = 1'b1;
          stateD = READ;
        end
      end
      READ: begin
        dataD   = rf_data;
        outIdxD = idxQ;
        validD  = 1'b1;
        stateD  = SEND;
      end
      SEND: begin
        if (out_ready) begin
          validD = 1'b0;
          if (idxQ == LAST_IDX) begin
            doneD  = 1'b1;
            stateD = FIN;
          end else begin
            idxD   = idxQ + ONE_IDX;
            stateD = READ;
          end
        end
      end
      FIN: begin
        busyD  = 1'b0;
        idxD   = '0;
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Read select tracks the sweep index; idx is parked at 0 while idle.
  assign rf_sel    = idxQ;
  assign out_valid = validQ;
  assign out_data  = dataQ;
  assign out_idx   = outIdxQ;
  assign busy      = busyQ;
  assign done      = doneQ;
  assign stale     = staleQ;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: a small register file model answers the read
// port, and a transfer-level model predicts every output cycle by cycle.
module tb_regfile_dump_ctrl;

  localparam int unsigned NREG = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  rfSel;
  logic [15:0] rfData;
  logic        wrEn;
  logic [2:0]  wrSel;
  logic        outValid;
  logic        outReady;
  logic [15:0] outData;
  logic [2:0]  outIdx;
  logic        busy;
  logic        done;
  logic        stale;

  regfile_dump_ctrl #(.NUM_REGS(8), .SEL_W(3), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rf_sel(rfSel), .rf_data(rfData),
    .wr_en(wrEn), .wr_sel(wrSel),
    .out_valid(outValid), .out_ready(outReady),
    .out_data(outData), .out_idx(outIdx),
    .busy(busy), .done(done), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write lands at the clock edge.
  logic [15:0] regs [NREG];
  assign rfData = regs[rfSel];

  int errors = 0;
  int checks = 0;

  // Transfer-level model of the sweep.
  int          cyc = 0;
  bit          mActive = 1'b0;
  int          mK = 0;
  int          mReadAt = 0;
  int          mDoneAt = -1;
  bit          mStale = 1'b0;
  logic [15:0] mData = '0;
  int          mSweeps = 0;
  int          startAt = 0;

  // Per-run observations.
  int          gotIdx [$];
  logic [15:0] gotData [$];
  int          doneCount;
  int          doneSeenAt;
  int          firstValidAt;
  bit          staleAtDone;
  bit          fired;
  bit          stopHit;

  // Drive values for the coming cycle.
  bit          startD;
  bit          readyD;
  bit          wrEnD;
  logic [2:0]  wrSelD;
  logic [15:0] wrDataD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mActive = 1'b0;
    mK      = 0;
    mDoneAt = -1;
    mStale  = 1'b0;
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < NREG; i++) begin
      regs[i] <= rnd ? 16'($urandom) : 16'(16'h1000 + i);
    end
    #0;
  endtask

  task automatic wr(input int sel, input logic [15:0] val);
    wrEnD   = 1'b1;
    wrSelD  = 3'(sel);
    wrDataD = val;
    fired   = 1'b1;
  endtask

  // One clock cycle: check the current outputs, apply drives, advance model.
  task automatic runCycle();
    bit inWin;
    bit isDoneCyc;
    isDoneCyc = mActive && (cyc == mDoneAt);
    inWin     = mActive && (mDoneAt < 0) && (cyc > mReadAt);
    chk("rfSel", 32'(rfSel), mActive ? 32'(mK) : 32'd0);
    chk("busy", 32'(busy), 32'(mActive));
    chk("done", 32'(done), 32'(isDoneCyc));
    chk("outValid", 32'(outValid), 32'(inWin));
    chk("stale", 32'(stale), 32'(mStale));
    if (mActive && (mDoneAt < 0) && (cyc == mReadAt)) mData = regs[3'(mK)];
    if (inWin && outValid) begin
      chk("outIdx", 32'(outIdx), 32'(mK));
      chk("outData", 32'(outData), 32'(mData));
    end
    if (outValid && firstValidAt < 0) firstValidAt = cyc;
    if (done) begin
      doneCount++;
      doneSeenAt  = cyc;
      staleAtDone = stale;
    end

    start    = startD;
    outReady = readyD;
    wrEn     = wrEnD;
    wrSel    = wrSelD;

    // A write during the sweep spoils the snapshot if its register was
    // already read at or before this cycle; in the done cycle only writes
    // below the last register count.
    if (mActive && wrEnD) begin
      if (isDoneCyc) begin
        if (int'(wrSelD) < NREG - 1) mStale = 1'b1;
      end else if (int'(wrSelD) <= mK) begin
        mStale = 1'b1;
      end
    end
    if (inWin && readyD) begin
      gotIdx.push_back(int'(outIdx));
      gotData.push_back(outData);
      if (mK == NREG - 1) mDoneAt = cyc + 1;
      else begin
        mK++;
        mReadAt = cyc + 1;
      end
    end
    if (isDoneCyc) begin
      modelEnd();
    end else if (!mActive && startD) begin
      mActive = 1'b1;
      mK      = 0;
      mReadAt = cyc + 1;
      mDoneAt = -1;
      mStale  = 1'b0;
      startAt = cyc;
    end

    @(posedge clk);
    if (wrEnD) regs[wrSelD] <= wrDataD;
    #1;
    cyc++;
  endtask

  task automatic modelEnd();
    mActive = 1'b0;
    mK      = 0;
    mDoneAt = -1;
    mSweeps++;
  endtask

  task automatic pickDrive(input int tid, input int n);
    startD  = (n == 0);
    readyD  = 1'b1;
    wrEnD   = 1'b0;
    wrSelD  = '0;
    wrDataD = '0;
    case (tid)
      2: readyD = (cyc % 3 == 0);
      3: if (mActive && mK == 5 && !fired) wr(2, 16'hBEEF);
      4: if (mActive && mK == 2 && !fired) wr(6, 16'hCAFE);
      5: if (mActive && mK == 3 && cyc == mReadAt && !fired) wr(3, 16'h0055);
      6: if (mActive && (mK == 1 || cyc == mDoneAt)) startD = 1'b1;
      7: begin
        readyD = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          wrEnD   = 1'b1;
          wrSelD  = 3'($urandom_range(0, 7));
          wrDataD = 16'($urandom);
        end
        if (mActive && $urandom_range(0, 3) == 0) startD = 1'b1;
      end
      8: begin
        readyD = !(mActive && mK == 4);
        if (mActive && mK == 2 && !fired) wr(0, 16'h1234);
      end
      default: ;
    endcase
  endtask

  task automatic runTest(input int tid);
    int extra;
    int endSweeps;
    gotIdx.delete();
    gotData.delete();
    doneCount    = 0;
    doneSeenAt   = -1;
    firstValidAt = -1;
    staleAtDone  = 1'b0;
    fired        = 1'b0;
    stopHit      = 1'b0;
    endSweeps    = mSweeps + 1;
    extra        = 0;
    for (int n = 0; n < 200; n++) begin
      pickDrive(tid, n);
      runCycle();
      if (tid == 8 && mActive && mK == 4 && mDoneAt < 0 && cyc > mReadAt) begin
        stopHit = 1'b1;
        break;
      end
      if (mSweeps >= endSweeps) extra++;
      if (extra == 3) break;
    end
    if (tid == 8) chk("reachSend4", 32'(stopHit), 32'd1);
    else chk("sweepEnds", 32'(mSweeps >= endSweeps), 32'd1);
  endtask

  // Transfers must be exactly idx 0..7 once each; data against the preload.
  task automatic checkXfers(input bit chkData, input int patchIdx, input logic [15:0] patchVal);
    logic [15:0] want;
    chk("xferCount", 32'(gotIdx.size()), 32'(NREG));
    chk("doneCount", 32'(doneCount), 32'd1);
    for (int i = 0; i < gotIdx.size() && i < NREG; i++) begin
      chk("xferIdx", 32'(gotIdx[i]), 32'(i));
      if (chkData) begin
        want = (i == patchIdx) ? patchVal : 16'(16'h1000 + i);
        chk("xferData", 32'(gotData[i]), 32'(want));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; outReady = 1'b0; wrEn = 1'b0; wrSel = '0;
    startD = 1'b0; readyD = 1'b0; wrEnD = 1'b0; wrSelD = '0; wrDataD = '0;
    preload(1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rstValid", 32'(outValid), 32'd0);
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstDone", 32'(done), 32'd0);
    chk("rstStale", 32'(stale), 32'd0);
    chk("rstSel", 32'(rfSel), 32'd0);
    chk("rstData", 32'(outData), 32'd0);
    chk("rstIdx", 32'(outIdx), 32'd0);
    rst = 1'b0;
    modelReset();

    // Straight sweep with ready held high.
    runTest(1);
    checkXfers(1'b1, -1, '0);
    chk("firstValidLat", 32'(firstValidAt - startAt), 32'd2);
    chk("doneLat", 32'(doneSeenAt - startAt), 32'd17);
    chk("staleClean", 32'(staleAtDone), 32'd0);

    // Back-pressure: ready one cycle in three.
    runTest(2);
    checkXfers(1'b1, -1, '0);
    chk("staleBp", 32'(staleAtDone), 32'd0);

    // Write behind the sweep.
    preload(1'b0);
    runTest(3);
    checkXfers(1'b1, -1, '0);
    chk("staleBehind", 32'(staleAtDone), 32'd1);

    // Write ahead of the sweep is picked up.
    preload(1'b0);
    runTest(4);
    checkXfers(1'b1, 6, 16'hCAFE);
    chk("staleAhead", 32'(staleAtDone), 32'd0);

    // Write in the very READ cycle: old value captured, stale set.
    preload(1'b0);
    runTest(5);
    checkXfers(1'b1, -1, '0);
    chk("staleSameCyc", 32'(staleAtDone), 32'd1);

    // Start while busy and in the done cycle is ignored.
    preload(1'b0);
    runTest(6);
    checkXfers(1'b1, -1, '0);

    // Asynchronous reset while holding a value at idx 4.
    preload(1'b0);
    runTest(8);
    chk("preRstValid", 32'(outValid), 32'd1);
    chk("preRstStale", 32'(stale), 32'd1);
    start = 1'b0; outReady = 1'b0; wrEn = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midRstValid", 32'(outValid), 32'd0);
    chk("midRstBusy", 32'(busy), 32'd0);
    chk("midRstSel", 32'(rfSel), 32'd0);
    chk("midRstStale", 32'(stale), 32'd0);
    chk("midRstDone", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    doneCount = 0;
    startD = 1'b0; readyD = 1'b1; wrEnD = 1'b0;
    repeat (3) runCycle();
    chk("noDoneAfterRst", 32'(doneCount), 32'd0);
    preload(1'b0);
    runTest(1);
    checkXfers(1'b1, -1, '0);

    // Randomised sweeps against the model.
    for (int s = 0; s < 6; s++) begin
      preload(1'b1);
      runTest(7);
      checkXfers(1'b0, -1, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
